// File: rtl/fetch_decode_sequencer_pkg.sv
// fetch_decode_sequencer_pkg: opcodes, state encodings and IR field positions shared with the execution stage
package fetch_decode_sequencer_pkg;
  localparam logic [4:0] OP_NOP    = 5'b00000;
  localparam logic [4:0] OP_ADD    = 5'b00001;
  localparam logic [4:0] OP_SHOWR  = 5'b10010;
  localparam logic [4:0] OP_SHOWRR = 5'b10011;
  localparam logic [4:0] OP_CMP    = 5'b10110;
  localparam logic [4:0] OP_JMP    = 5'b10111;
  localparam logic [4:0] OP_JE     = 5'b11000;
  localparam logic [4:0] OP_LI     = 5'b11101;
  localparam logic [4:0] OP_HALT   = 5'b11111;
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 11;
  localparam int RD_HI  = 10;
  localparam int RD_LO  = 8;
  localparam int RS_HI  = 7;
  localparam int RS_LO  = 5;
  localparam int IMM_HI = 2;
  localparam int IMM_LO = 0;
  localparam int JA_HI  = 7;
  localparam int JA_LO  = 0;
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_t;
  // Register-writing opcodes; CMP, jumps, NOP, SHOW and undefined codes fall outside these ranges
  function automatic logic op_writes_reg(input logic [4:0] op);
    return (op >= 5'b00001 && op <= 5'b01011) || (op >= 5'b01101 && op <= 5'b10000) ||
           op == 5'b10100 || op == OP_LI;
  endfunction
endpackage

// File: rtl/fetch_decode_sequencer_decoder.sv
// fetch_decode_sequencer_decoder: combinational IR field split and write/show/halt classification
module fetch_decode_sequencer_decoder
  import fetch_decode_sequencer_pkg::*;
#(
  parameter logic [4:0] HALT_OPCODE = OP_HALT
) (
  input  logic [15:0] ir,
  input  logic [4:0]  next_op,
  output logic [4:0]  opcode,
  output logic [2:0]  rd,
  output logic [2:0]  rs,
  output logic [2:0]  imm,
  output logic [7:0]  jaddr,
  output logic        writes_reg,
  output logic        is_show,
  output logic        is_halt
);
  assign opcode     = ir[OP_HI:OP_LO];
  assign rd         = ir[RD_HI:RD_LO];
  assign rs         = ir[RS_HI:RS_LO];
  assign imm        = ir[IMM_HI:IMM_LO];
  assign jaddr      = ir[JA_HI:JA_LO];
  assign writes_reg = op_writes_reg(opcode);
  assign is_show    = opcode == OP_SHOWR || opcode == OP_SHOWRR;
  // Halt is detected on the word being loaded into IR so the sequencer stops right after DECODE
  assign is_halt    = next_op == HALT_OPCODE;
endmodule

// File: rtl/fetch_decode_sequencer.sv
// fetch_decode_sequencer: four-phase fetch/decode control stage owning PC, IR and the flag register
module fetch_decode_sequencer
  import fetch_decode_sequencer_pkg::*;
#(
  parameter int                  PC_WIDTH    = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [4:0]          HALT_OPCODE = OP_HALT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Enable,
  output logic [PC_WIDTH-1:0] InstrAddr,
  input  logic [15:0]         InstrData,
  output logic [4:0]          AluOperation,
  output logic [2:0]          RdAddr,
  output logic [2:0]          RsAddr,
  output logic [2:0]          immediate,
  output logic [7:0]          jump_address,
  input  logic                ConditionalJump,
  input  logic                S,
  input  logic                Z,
  input  logic                C,
  input  logic                O,
  output logic                Sin,
  output logic                Zin,
  output logic                Cin,
  output logic                Oin,
  output logic                RegWrite,
  output logic                ShowStrobe,
  output logic                Halted,
  output logic [1:0]          Phase
);
  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [15:0]         ir;
  logic [3:0]          flags;
  logic                reg_write_q;
  logic                show_q;
  logic                writes_reg;
  logic                is_show;
  logic                is_halt;
  fetch_decode_sequencer_decoder #(.HALT_OPCODE(HALT_OPCODE)) u_dec (
    .ir        (ir),
    .next_op   (InstrData[OP_HI:OP_LO]),
    .opcode    (AluOperation),
    .rd        (RdAddr),
    .rs        (RsAddr),
    .imm       (immediate),
    .jaddr     (jump_address),
    .writes_reg(writes_reg),
    .is_show   (is_show),
    .is_halt   (is_halt)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      ir          <= '0;
      flags       <= '0;
      reg_write_q <= 1'b0;
      show_q      <= 1'b0;
    end else if (Enable) begin
      case (state)
        ST_FETCH:  state <= ST_DECODE;
        ST_DECODE: begin
          ir    <= InstrData;
          state <= is_halt ? ST_HALT : ST_EXEC;
        end
        ST_EXEC: begin
          reg_write_q <= writes_reg;
          show_q      <= is_show;
          state       <= ST_WB;
        end
        ST_WB: begin
          flags       <= {S, Z, C, O};
          pc          <= ConditionalJump ? PC_WIDTH'(jump_address) : pc + 1'b1;
          reg_write_q <= 1'b0;
          show_q      <= 1'b0;
          state       <= ST_FETCH;
        end
        ST_HALT: ;
        default: state <= ST_FETCH;
      endcase
    end
  // Strobes are gated by Enable so a frozen WB cycle emits nothing until it actually completes
  assign RegWrite   = reg_write_q & Enable;
  assign ShowStrobe = show_q & Enable;
  assign InstrAddr  = pc;
  assign {Sin, Zin, Cin, Oin} = flags;
  assign Halted     = state == ST_HALT;
  assign Phase      = state == ST_HALT ? 2'd3 : state[1:0];
endmodule
